// File: rtl/shift_seq_ctrl.sv
// Sequencer for a 4-bit universal shift register (mode mux + DFF per bit).
// Accepts TX / RX / ROT / LOAD requests over a valid/ready handshake, drives the
// register's mode/data/serial-in pins and reports completion with the final Q value.
// Optional even-parity tracking of shifted bits is enabled by defining SHIFT_SEQ_PARITY_EN.
module shift_seq_ctrl #(
  parameter int unsigned MAX_SHIFT = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [3:0]       req_data,
  input  logic [CNT_W-1:0] req_count,
  input  logic             ser_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic [1:0]       sr_M,
  output logic [3:0]       sr_D,
  output logic             sr_SI,
  input  logic [3:0]       sr_Q,
  output logic             done,
  output logic [3:0]       result,
  output logic             parity_out
);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  localparam logic [1:0] OpTx   = 2'b00;
  localparam logic [1:0] OpRx   = 2'b01;
  localparam logic [1:0] OpRot  = 2'b10;
  localparam logic [1:0] OpLoad = 2'b11;

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_SHIFT);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [3:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       result_q;
  logic [CNT_W-1:0] count_clamped;
  logic             hs;

  assign hs            = req_valid & req_ready;
  assign count_clamped = (req_count > MaxCnt) ? MaxCnt : req_count;

  // Next-state, request latch and shift counter.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (hs) begin
          op_d   = req_op;
          data_d = req_data;
          cnt_d  = count_clamped;
          if (req_op == OpRx) begin
            state_d = (count_clamped == '0) ? StDone : StShift;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        state_d = ((op_q == OpLoad) || (cnt_q == '0)) ? StDone : StShift;
      end
      StShift: begin
        cnt_d = cnt_q - CntOne;
        if (cnt_q <= CntOne) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Moore pin decode; everything is forced quiet while reset is asserted.
  always_comb begin
    req_ready = 1'b0;
    sr_M      = 2'b00;
    sr_D      = 4'b0000;
    sr_SI     = 1'b0;
    ser_valid = 1'b0;
    done      = 1'b0;
    if (rst) begin
      unique case (state_q)
        StIdle:  req_ready = 1'b1;
        StLoad: begin
          sr_M = 2'b01;
          sr_D = data_q;
        end
        StShift: begin
          sr_M      = (op_q == OpRot) ? 2'b10 : 2'b11;
          sr_SI     = (op_q == OpRx) ? ser_in : 1'b0;
          ser_valid = (op_q == OpTx);
        end
        StDone:  done = 1'b1;
        default: ;
      endcase
    end
  end

  assign ser_out = ser_valid & sr_Q[0];
  assign result  = result_q;

  // State, request fields and captured result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= OpTx;
      data_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      if (state_q == StDone) result_q <= sr_Q;
    end
  end

`ifdef SHIFT_SEQ_PARITY_EN
  logic par_q, par_d;
  logic parity_q;

  // Running XOR of bits leaving (TX) or entering (RX) the register.
  always_comb begin
    par_d = par_q;
    if (state_q == StIdle && hs) begin
      par_d = 1'b0;
    end else if (state_q == StShift) begin
      if (op_q == OpTx) par_d = par_q ^ sr_Q[0];
      else if (op_q == OpRx) par_d = par_q ^ ser_in;
    end
  end

  // Parity accumulator and the copy published alongside result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      par_q    <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      par_q <= par_d;
      if (state_q == StDone) parity_q <= par_q;
    end
  end

  assign parity_out = parity_q;
`else
  assign parity_out = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl with a behavioural 4-bit universal shift
// register attached. Expected results are queued at request time and retired on done.
module tb_shift_seq_ctrl;

  localparam logic [1:0] OpTx   = 2'b00;
  localparam logic [1:0] OpRx   = 2'b01;
  localparam logic [1:0] OpRot  = 2'b10;
  localparam logic [1:0] OpLoad = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_data;
  logic [2:0] req_count;
  logic       ser_in;
  logic       ser_out;
  logic       ser_valid;
  logic [1:0] sr_M;
  logic [3:0] sr_D;
  logic       sr_SI;
  logic [3:0] sr_Q;
  logic       done;
  logic [3:0] result;
  logic       parity_out;

  logic [3:0] reg_q = 4'b0000;

  typedef struct {
    logic [1:0] op;
    logic [3:0] res;
    logic       par;
    int         lat;
    int         nser;
    logic [3:0] ser;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  int n_total = 0;
  int n_pass  = 0;
  int ncyc    = 0;
  int hs_cyc  = 0;
  int nser_obs = 0;
  logic [3:0] ser_obs = 4'b0000;
  bit pend = 1'b0;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.MAX_SHIFT(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_data   (req_data),
    .req_count  (req_count),
    .ser_in     (ser_in),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .sr_M       (sr_M),
    .sr_D       (sr_D),
    .sr_SI      (sr_SI),
    .sr_Q       (sr_Q),
    .done       (done),
    .result     (result),
    .parity_out (parity_out)
  );

  // Behavioural universal shift register driven by the controller.
  always @(posedge clk) begin
    case (sr_M)
      2'b01:   reg_q <= sr_D;
      2'b10:   reg_q <= {reg_q[2:0], reg_q[3]};
      2'b11:   reg_q <= {sr_SI, reg_q[3:1]};
      default: reg_q <= reg_q;
    endcase
  end
  assign sr_Q = reg_q;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [3:0] data,
                                 input logic [2:0] cnt, input logic [3:0] rx,
                                 input logic [3:0] q0);
    exp_t e;
    logic [3:0] q;
    int c;
    c      = (cnt > 3'd4) ? 4 : int'(cnt);
    e.op   = op;
    e.nser = 0;
    e.ser  = 4'b0000;
    e.par  = 1'b0;
    q      = data;
    case (op)
      OpTx: begin
        for (int i = 0; i < c; i++) begin
          e.ser[i] = q[0];
          e.par    = e.par ^ q[0];
          q        = {1'b0, q[3:1]};
        end
        e.nser = c;
        e.lat  = 2 + c;
      end
      OpRx: begin
        q = q0;
        for (int i = 0; i < c; i++) begin
          q     = {rx[i], q[3:1]};
          e.par = e.par ^ rx[i];
        end
        e.lat = 1 + c;
      end
      OpRot: begin
        for (int i = 0; i < c; i++) q = {q[2:0], q[3]};
        e.lat = 2 + c;
      end
      default: e.lat = 2;
    endcase
    e.res = q;
`ifndef SHIFT_SEQ_PARITY_EN
    e.par = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard retirement: latency, TX serial stream, then result one cycle after done.
  always @(negedge clk) begin
    if (rst === 1'b1 && req_valid === 1'b1 && req_ready === 1'b1) begin
      hs_cyc   = ncyc;
      nser_obs = 0;
      ser_obs  = 4'b0000;
    end
    if (ser_valid === 1'b1) begin
      if (nser_obs < 4) ser_obs[nser_obs] = ser_out;
      nser_obs++;
    end
    if (pend) begin
      chk("result", {4'b0, result}, {4'b0, cur.res});
      chk("parity_out", {7'b0, parity_out}, {7'b0, cur.par});
      pend = 1'b0;
    end
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 8'd1, 8'd0);
      end else begin
        cur = sb.pop_front();
        chk("latency", 8'(ncyc - hs_cyc), 8'(cur.lat));
        if (cur.op == OpTx) begin
          chk("ser_count", 8'(nser_obs), 8'(cur.nser));
          chk("ser_bits", {4'b0, ser_obs}, {4'b0, cur.ser});
        end
        pend = 1'b1;
      end
    end
    ncyc++;
  end

  task automatic wait_hs();
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hs_wait", {7'b0, (n < 50)}, 8'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_to_done(input logic [1:0] op, input logic [3:0] data,
                             input logic [2:0] cnt, input logic [3:0] rx, input bit busy);
    int n = 0;
    int k = 0;
    int nsh = 0;
    int exp_sh;
    bit seen = 1'b0;
    exp_sh = (op == OpLoad) ? 0 : ((cnt > 3'd4) ? 4 : int'(cnt));
    while (!seen && n < 30) begin
      if (op == OpRx && sr_M === 2'b11 && k < 4) begin
        ser_in = rx[k];
        k++;
      end
      if (n == 0 && op != OpRx) begin
        chk("load_mode", {6'b0, sr_M}, 8'h01);
        chk("load_data", {4'b0, sr_D}, {4'b0, data});
      end else begin
        chk("sr_D_idle", {4'b0, sr_D}, 8'h00);
      end
      if (sr_M === 2'b10 || sr_M === 2'b11) begin
        nsh++;
        chk("shift_mode", {6'b0, sr_M}, (op == OpRot) ? 8'h02 : 8'h03);
      end
      if (done === 1'b1) seen = 1'b1;
      else if (busy) chk("busy_ready", {7'b0, req_ready}, 8'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("done_wait", {7'b0, seen}, 8'd1);
    chk("shift_cycles", 8'(nsh), 8'(exp_sh));
    ser_in = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt,
                      input logic [3:0] rx, input bit hold, input logic [3:0] hdata);
    sb.push_back(model(op, data, cnt, rx, reg_q));
    req_op    = op;
    req_data  = data;
    req_count = cnt;
    req_valid = 1'b1;
    wait_hs();
    if (hold) begin
      req_op    = OpLoad;
      req_data  = hdata;
      req_count = 3'd0;
      sb.push_back(model(OpLoad, hdata, 3'd0, 4'b0, reg_q));
    end else begin
      req_valid = 1'b0;
    end
    run_to_done(op, data, cnt, rx, hold);
    if (hold) begin
      wait_hs();
      req_valid = 1'b0;
      run_to_done(OpLoad, hdata, 3'd0, 4'b0, 1'b0);
    end
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_data  = 4'b0;
    req_count = 3'd0;
    ser_in    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {7'b0, req_ready}, 8'd0);
    chk("rst_mode", {6'b0, sr_M}, 8'd0);
    chk("rst_sr_D", {4'b0, sr_D}, 8'd0);
    chk("rst_ser_valid", {7'b0, ser_valid}, 8'd0);
    chk("rst_done", {7'b0, done}, 8'd0);
    chk("rst_result", {4'b0, result}, 8'd0);
    chk("rst_parity", {7'b0, parity_out}, 8'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", {7'b0, req_ready}, 8'd1);

    send(OpLoad, 4'b0110, 3'd0, 4'b0, 1'b0, 4'b0);

    // Abort a TX with reset: no done, result cleared, ready returns afterwards.
    req_op = OpTx; req_data = 4'b1011; req_count = 3'd4; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("midtx_ser_valid", {7'b0, ser_valid}, 8'd1);
    rst = 1'b0;
    #1;
    chk("abort_ready", {7'b0, req_ready}, 8'd0);
    chk("abort_mode", {6'b0, sr_M}, 8'd0);
    chk("abort_ser_valid", {7'b0, ser_valid}, 8'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_ready_hold", {7'b0, req_ready}, 8'd0);
      chk("abort_mode_hold", {6'b0, sr_M}, 8'd0);
      chk("abort_done", {7'b0, done}, 8'd0);
    end
    chk("abort_result", {4'b0, result}, 8'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_abort", {7'b0, req_ready}, 8'd1);

    send(OpTx,   4'b1011, 3'd4, 4'b0000, 1'b0, 4'b0);
    send(OpRx,   4'b0000, 3'd4, 4'b1001, 1'b0, 4'b0);
    send(OpRot,  4'b0001, 3'd3, 4'b0000, 1'b0, 4'b0);
    send(OpTx,   4'b0110, 3'd7, 4'b0000, 1'b0, 4'b0);
    send(OpLoad, 4'b0110, 3'd0, 4'b0000, 1'b0, 4'b0);
    send(OpRx,   4'b0000, 3'd0, 4'b0000, 1'b0, 4'b0);
    send(OpRx,   4'b0000, 3'd2, 4'b0011, 1'b0, 4'b0);
    send(OpTx,   4'b1101, 3'd2, 4'b0000, 1'b1, 4'b1010);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 8'(sb.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
